// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_if
// Description : Bundles the fetch stage's ROM address/data pair, the redirect
//               request and the decoder-side valid/ready instruction channel.
//               master = fetch unit side, slave = ROM/decoder/control side.
// Ports       : rom_addr/rom_data      word address out, registered data in
//               redirect_valid/_pc     PC stream replacement request
//               instr_valid/_ready     decoder handshake
//               instr/instr_pc         instruction at buffer head and its PC
//               fetch_fault            sticky illegal-PC indication
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        fetch_fault;

  modport master (
    output rom_addr,
    input  rom_data,
    input  redirect_valid,
    input  redirect_pc,
    output instr_valid,
    input  instr_ready,
    output instr,
    output instr_pc,
    output fetch_fault
  );

  modport slave (
    input  rom_addr,
    output rom_data,
    output redirect_valid,
    output redirect_pc,
    input  instr_valid,
    output instr_ready,
    input  instr,
    input  instr_pc,
    input  fetch_fault
  );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage. Generates the PC, drives the word
//               address of a 1-cycle-latency ROM, and delivers instructions
//               with their PC to decode through a 2-entry output FIFO.
//               Supports redirect (flush + refetch) and a sticky fault on
//               fetches outside the ROM or misaligned.
// Ports       : clk     rising-edge clock
//               resetn  synchronous active-low reset
//               bus     fetch_unit_if.master (ROM, redirect, decoder channel)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ROM_SIZE = 128
) (
  input  wire logic     clk,
  input  wire logic     resetn,
  fetch_unit_if.master  bus
);

  localparam logic [29:0] c_ROM_WORDS = 30'(ROM_SIZE);

  logic [31:0] r_pc;
  logic        r_inflight_valid;
  logic [31:0] r_inflight_pc;
  logic        r_fault;
  logic [31:0] r_buf_data [2];
  logic [31:0] r_buf_pc   [2];
  logic        r_rd_ptr;
  logic [1:0]  r_count;

  logic [31:0] w_fetch_pc;
  logic        w_legal;
  logic        w_pop;
  logic        w_push;
  logic        w_kept;
  logic [1:0]  w_count_next;
  logic        w_credit;
  logic        w_allow;
  logic        w_issue;
  logic        w_fault_set;
  logic        w_wr_ptr;

  assign w_fetch_pc = bus.redirect_valid ? bus.redirect_pc : r_pc;
  assign w_legal    = (w_fetch_pc[1:0] == 2'b00) && (w_fetch_pc[31:2] < c_ROM_WORDS);

  assign w_pop  = (r_count != 2'd0) && bus.instr_ready;
  // A redirect discards the inflight read, so its data is never captured.
  assign w_kept = r_inflight_valid && !bus.redirect_valid;
  assign w_push = w_kept;

  assign w_count_next = bus.redirect_valid ? 2'd0 : (r_count - {1'b0, w_pop});
  // Buffered + inflight may never exceed two, so a capture always finds room.
  assign w_credit     = ({1'b0, w_count_next} + {2'b00, w_kept}) < 3'd2;

  assign w_allow     = (!r_fault || bus.redirect_valid) && w_credit;
  assign w_issue     = w_allow && w_legal;
  assign w_fault_set = w_allow && !w_legal;

  // Write slot sits just behind the head; only reachable when count <= 1.
  assign w_wr_ptr = r_rd_ptr ^ r_count[0];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_pc             <= RESET_PC;
      r_inflight_valid <= 1'b0;
      r_inflight_pc    <= 32'h0;
      r_fault          <= 1'b0;
      r_buf_data[0]    <= 32'h0;
      r_buf_data[1]    <= 32'h0;
      r_buf_pc[0]      <= 32'h0;
      r_buf_pc[1]      <= 32'h0;
      r_rd_ptr         <= 1'b0;
      r_count          <= 2'd0;
    end else begin
      if (w_issue) begin
        r_inflight_valid <= 1'b1;
        r_inflight_pc    <= w_fetch_pc;
        r_pc             <= w_fetch_pc + 32'd4;
      end else begin
        r_inflight_valid <= 1'b0;
        if (bus.redirect_valid) begin
          r_pc <= bus.redirect_pc;
        end
      end

      if (w_fault_set) begin
        r_fault <= 1'b1;
      end else if (bus.redirect_valid && w_legal) begin
        r_fault <= 1'b0;
      end

      if (w_push) begin
        r_buf_data[w_wr_ptr] <= bus.rom_data;
        r_buf_pc[w_wr_ptr]   <= r_inflight_pc;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= w_count_next + {1'b0, w_push};
    end
  end

  assign bus.rom_addr    = !resetn ? {2'b00, RESET_PC[31:2]} : {2'b00, w_fetch_pc[31:2]};
  assign bus.instr_valid = (r_count != 2'd0);
  assign bus.instr       = r_buf_data[r_rd_ptr];
  assign bus.instr_pc    = r_buf_pc[r_rd_ptr];
  assign bus.fetch_fault = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit. A per-cycle vector table
//               covers reset, streaming, backpressure, redirect, fault and
//               mid-stream reset; a scored stream with a ready pattern checks
//               contiguous in-order delivery.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  logic clk;
  logic resetn;

  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .ROM_SIZE (128)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: word i holds 0xA000_0000 + i, registered read.
  always @(posedge clk) begin
    if (bus.rom_addr < 32'd128) bus.rom_data <= 32'hA000_0000 + bus.rom_addr;
    else                        bus.rom_data <= 32'hDEAD_BEEF;
  end

  int checks = 0;
  int errors = 0;
  logic saw_200 = 1'b0;

  always @(posedge clk) begin
    if (bus.instr_valid && bus.instr_pc == 32'h200) saw_200 <= 1'b1;
  end

  typedef struct {
    logic        rstn;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        ca;
    logic [31:0] eaddr;
    logic        ev;
    logic        cd;
    logic [31:0] einstr;
    logic [31:0] epc;
    logic        ef;
  } vec_t;

  vec_t vt [34];

  function automatic vec_t mk(input logic rstn, input logic rv, input logic [31:0] rpc,
                              input logic rdy, input logic ca, input logic [31:0] eaddr,
                              input logic ev, input logic cd, input logic [31:0] einstr,
                              input logic [31:0] epc, input logic ef);
    vec_t v;
    v.rstn = rstn; v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.ca = ca; v.eaddr = eaddr;
    v.ev = ev; v.cd = cd; v.einstr = einstr; v.epc = epc; v.ef = ef;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s vec=%0d got=%h exp=%h", name, idx, got, exp);
    end
  endtask

  initial begin
    //           rstn rv rpc        rdy ca eaddr  ev cd einstr        epc     ef
    vt[0]  = mk(0, 0, 32'h0,   1, 1, 32'h0,  0, 1, 32'h0,        32'h0,   0);
    vt[1]  = mk(0, 0, 32'h0,   1, 0, 32'h0,  0, 1, 32'h0,        32'h0,   0);
    vt[2]  = mk(1, 0, 32'h0,   1, 1, 32'h0,  0, 1, 32'h0,        32'h0,   0);
    vt[3]  = mk(1, 0, 32'h0,   1, 1, 32'h1,  1, 1, 32'hA000_0000, 32'h0,  0);
    vt[4]  = mk(1, 0, 32'h0,   1, 0, 32'h0,  1, 1, 32'hA000_0001, 32'h4,  0);
    vt[5]  = mk(1, 0, 32'h0,   0, 0, 32'h0,  1, 1, 32'hA000_0001, 32'h4,  0);
    vt[6]  = mk(1, 0, 32'h0,   0, 0, 32'h0,  1, 1, 32'hA000_0001, 32'h4,  0);
    vt[7]  = mk(1, 0, 32'h0,   0, 0, 32'h0,  1, 1, 32'hA000_0001, 32'h4,  0);
    vt[8]  = mk(1, 0, 32'h0,   0, 0, 32'h0,  1, 1, 32'hA000_0001, 32'h4,  0);
    vt[9]  = mk(1, 0, 32'h0,   1, 0, 32'h0,  1, 1, 32'hA000_0002, 32'h8,  0);
    vt[10] = mk(1, 0, 32'h0,   1, 0, 32'h0,  1, 1, 32'hA000_0003, 32'hC,  0);
    vt[11] = mk(1, 0, 32'h0,   1, 0, 32'h0,  1, 1, 32'hA000_0004, 32'h10, 0);
    vt[12] = mk(1, 0, 32'h0,   0, 0, 32'h0,  1, 1, 32'hA000_0004, 32'h10, 0);
    vt[13] = mk(1, 1, 32'h40,  0, 1, 32'h10, 0, 0, 32'h0,        32'h0,   0);
    vt[14] = mk(1, 0, 32'h0,   0, 0, 32'h0,  1, 1, 32'hA000_0010, 32'h40, 0);
    vt[15] = mk(1, 0, 32'h0,   1, 0, 32'h0,  1, 1, 32'hA000_0011, 32'h44, 0);
    vt[16] = mk(1, 1, 32'h42,  1, 1, 32'h10, 0, 0, 32'h0,        32'h0,   1);
    vt[17] = mk(1, 0, 32'h0,   1, 0, 32'h0,  0, 0, 32'h0,        32'h0,   1);
    vt[18] = mk(1, 0, 32'h0,   1, 0, 32'h0,  0, 0, 32'h0,        32'h0,   1);
    vt[19] = mk(1, 1, 32'h8,   1, 1, 32'h2,  0, 0, 32'h0,        32'h0,   0);
    vt[20] = mk(1, 0, 32'h0,   1, 0, 32'h0,  1, 1, 32'hA000_0002, 32'h8,  0);
    vt[21] = mk(1, 0, 32'h0,   1, 0, 32'h0,  1, 1, 32'hA000_0003, 32'hC,  0);
    vt[22] = mk(1, 1, 32'h1F8, 1, 1, 32'h7E, 0, 0, 32'h0,        32'h0,   0);
    vt[23] = mk(1, 0, 32'h0,   1, 0, 32'h0,  1, 1, 32'hA000_007E, 32'h1F8, 0);
    vt[24] = mk(1, 0, 32'h0,   1, 1, 32'h80, 1, 1, 32'hA000_007F, 32'h1FC, 1);
    vt[25] = mk(1, 0, 32'h0,   1, 0, 32'h0,  0, 0, 32'h0,        32'h0,   1);
    vt[26] = mk(1, 0, 32'h0,   1, 0, 32'h0,  0, 0, 32'h0,        32'h0,   1);
    vt[27] = mk(1, 1, 32'h0,   0, 1, 32'h0,  0, 0, 32'h0,        32'h0,   0);
    vt[28] = mk(1, 0, 32'h0,   0, 0, 32'h0,  1, 1, 32'hA000_0000, 32'h0,  0);
    vt[29] = mk(1, 0, 32'h0,   0, 0, 32'h0,  1, 1, 32'hA000_0000, 32'h0,  0);
    vt[30] = mk(0, 0, 32'h0,   0, 1, 32'h0,  0, 1, 32'h0,        32'h0,   0);
    vt[31] = mk(1, 0, 32'h0,   1, 0, 32'h0,  0, 1, 32'h0,        32'h0,   0);
    vt[32] = mk(1, 0, 32'h0,   1, 0, 32'h0,  1, 1, 32'hA000_0000, 32'h0,  0);
    vt[33] = mk(1, 0, 32'h0,   1, 0, 32'h0,  1, 1, 32'hA000_0001, 32'h4,  0);

    resetn             = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.instr_ready    = 1'b0;

    for (int i = 0; i < 34; i++) begin
      @(negedge clk);
      resetn             = vt[i].rstn;
      bus.redirect_valid = vt[i].rv;
      bus.redirect_pc    = vt[i].rpc;
      bus.instr_ready    = vt[i].rdy;
      #1;
      if (vt[i].ca) check("rom_addr", i, bus.rom_addr, vt[i].eaddr);
      @(posedge clk);
      #1;
      check("instr_valid", i, {31'b0, bus.instr_valid}, {31'b0, vt[i].ev});
      check("fetch_fault", i, {31'b0, bus.fetch_fault}, {31'b0, vt[i].ef});
      if (vt[i].cd) begin
        check("instr", i, bus.instr, vt[i].einstr);
        check("instr_pc", i, bus.instr_pc, vt[i].epc);
      end
    end

    // Scored stream: head is PC 0x4; ready pattern 1,1,0 repeating.
    begin
      logic [31:0] exp_pc;
      int xfers;
      exp_pc = 32'h4;
      xfers  = 0;
      bus.redirect_valid = 1'b0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        bus.instr_ready = (c % 3 != 2);
        #1;
        if (bus.instr_valid && bus.instr_ready) begin
          check("stream_pc", 100 + c, bus.instr_pc, exp_pc);
          check("stream_instr", 100 + c, bus.instr, 32'hA000_0000 + (exp_pc >> 2));
          exp_pc = exp_pc + 32'd4;
          xfers++;
        end
      end
      check("stream_xfers_ge20", 200, {31'b0, (xfers >= 20)}, 32'd1);
    end

    check("pc_200_never_seen", 201, {31'b0, saw_200}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage that generates the program counter and drives the word address of the synchronous instruction ROM controller.
- Absorbs the ROM's 1-cycle read latency and presents fetched instructions with their PC to the decoder over a valid/ready handshake.
- Supports branch/jump redirect and backpressure through a 2-entry output buffer.
- Sits between the ROM controller (its address/data partner) and decode.

Parameters:
RESET_PC, 32'h0000_0000, byte PC fetched first after reset; must be word-aligned.
ROM_SIZE, 128, ROM depth in 32-bit words; legal PCs are 0 .. 4*ROM_SIZE-4.

Ports:
clk  input  1  single clock, rising edge.
resetn  input  1  reset, synchronous, active-low.
rom_addr  output  32  word index to ROM: {2'b00, fetch_pc[31:2]}; ROM samples it at each rising edge.
rom_data  input  32  ROM registered read data for the address sampled at the previous edge.
redirect_valid  input  1  replace PC stream this cycle.
redirect_pc  input  32  new byte PC.
instr_valid  output  1  buffer head holds a valid instruction.
instr_ready  input  1  decoder accepts head; transfer = instr_valid & instr_ready.
instr  output  32  instruction word at buffer head.
instr_pc  output  32  byte PC of instr.
fetch_fault  output  1  sticky: fetch halted on illegal PC.

Behaviour:
- Reset (resetn=0 at an edge), applies regardless of any other input, including mid-stream:
  - pc_q <= RESET_PC; inflight_valid <= 0; buffer emptied; fetch_fault <= 0.
  - Outputs after that edge: instr_valid=0, instr=0, instr_pc=0, fetch_fault=0.
  - rom_addr = RESET_PC>>2 while in reset.
- fetch_pc (combinational) = redirect_valid ? redirect_pc : pc_q. rom_addr is derived from fetch_pc.
- legal = (fetch_pc[1:0]==0) & (fetch_pc[31:2] < ROM_SIZE).
- Issue at an edge when all of the following hold:
  - resetn=1
  - !fetch_fault, or redirect_valid with legal target
  - legal
  - credit: count_next + inflight_kept < 2, where count_next is buffer occupancy after this edge's pop/flush and inflight_kept is inflight_valid & !redirect_valid.
- On issue: inflight_valid <= 1, inflight_pc <= fetch_pc, pc_q <= fetch_pc + 4 (32-bit wrap).
- No issue: inflight_valid <= 0; pc_q holds, or takes redirect_pc on redirect.
- Capture: when inflight_valid=1 and no redirect this cycle, rom_data and inflight_pc are written into the buffer at the edge.
- Latency:
  - Issue at edge E → data captured at E+1 → instr_valid visible after E+1.
  - First instruction after reset release: 2 edges.
  - Steady-state throughput: 1 instr/cycle with instr_ready=1.
- Buffer: 2-entry FIFO, head drives instr/instr_pc.
  - Same-edge pop and push allowed.
  - The credit rule guarantees no overflow; no instruction is ever dropped or duplicated under backpressure.
  - When empty: instr_valid=0; instr and instr_pc hold their last values (don't-care).
- Redirect (priority over everything except reset):
  - A transfer occurring in the same cycle is still consumed by the decoder.
  - At the edge, all buffer entries and the inflight request are discarded.
  - redirect_pc is issued this same cycle if legal. First redirected instr_valid appears 2 edges later; no stale instruction ever appears after the redirect edge.
- Fault: if issue is otherwise allowed but fetch_pc is illegal:
  - fetch_fault <= 1 and no issue.
  - Already buffered/inflight valid instructions still drain, unless a redirect is present.
  - fetch_fault clears only on reset or a redirect to a legal PC (which issues in that cycle).
  - A redirect to an illegal PC flushes and sets fault.
- Sequential fetch reaching 4*ROM_SIZE is illegal → fault. No wrap into the ROM.

Test Plan:
- Reset release, instr_ready=1, ROM word i = 0xA000_0000+i → instr_valid rises 2 edges after release; instr_pc 0x0,0x4,0x8… one per cycle; instr 0xA000_0000,+1,+2 matching.
- Steady stream, instr_ready held 0 for 4 cycles → instr_valid stays 1, head unchanged, issuing stops at 2 buffered/inflight; after release, PCs continue contiguously with no gap or duplicate.
- Redirect to 0x40 while buffer full and instr_ready=0 → flush; next transferred instr_pc=0x40, instr=0xA000_0010; no earlier PC appears afterward.
- Redirect to 0x42 → fetch_fault=1, instr_valid=0, no further issue; then redirect to 0x8 → fault clears same edge, next instr_pc=0x8.
- ROM_SIZE=128, redirect to 0x1F8 → instructions 0x1F8, 0x1FC delivered, then fetch_fault=1; 0x200 never issued.
- resetn low for 1 cycle mid-stream with buffer full → next edge all outputs 0; fetch restarts at RESET_PC, first instr after 2 edges.
